fifo_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter in the wclk domain, sharing one async FIFO write port (wr_en/wdata/full) among NREQ producers.
- Grants are burst-locked, so a packet of up to MAX_BURST beats from one requester reaches the FIFO contiguously.
- Sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter and round-robin picker.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StBusy
   } arb_state_e;

   localparam int unsigned ARB_NREQ      = 4;
   localparam int unsigned ARB_WD        = 40;
   localparam int unsigned ARB_MAX_BURST = 8;
   localparam int unsigned STAT_W        = 16;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: first set request strictly after last_grant_i, wrapping.
module rr_pick #(
   parameter int unsigned NReq = 4,
   localparam int unsigned IdW = $clog2(NReq)
) (
   input  logic [NReq-1:0] req_i,
   input  logic [IdW-1:0]  last_grant_i,
   output logic [IdW-1:0]  grant_o,
   output logic            any_o
);

   logic           found_hi;
   logic [IdW-1:0] idx_hi;
   logic           found_lo;
   logic [IdW-1:0] idx_lo;

   // Two ascending passes: indices above last_grant_i win, then the wrapped range.
   always_comb begin
      found_hi = 1'b0;
      idx_hi   = '0;
      found_lo = 1'b0;
      idx_lo   = '0;
      for (int unsigned i = 0; i < NReq; i++) begin
         if (!found_hi && req_i[i] && (i > 32'(last_grant_i))) begin
            found_hi = 1'b1;
            idx_hi   = IdW'(i);
         end
         if (!found_lo && req_i[i] && (i <= 32'(last_grant_i))) begin
            found_lo = 1'b1;
            idx_lo   = IdW'(i);
         end
      end
      any_o   = found_hi | found_lo;
      grant_o = found_hi ? idx_hi : idx_lo;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among NREQ producers.
// Optional per-requester beat counters when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ      = ARB_NREQ,
   parameter int unsigned WD        = ARB_WD,
   parameter int unsigned MAX_BURST = ARB_MAX_BURST,
   localparam int unsigned IDW      = $clog2(NREQ)
) (
   input  logic                   wclk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_last,
   input  logic [NREQ*WD-1:0]     req_data,
   output logic [NREQ-1:0]        req_ready,
`ifdef FIFO_WR_ARB_STATS_EN
   input  logic                   stat_clr,
   output logic [NREQ*STAT_W-1:0] stat_beats,
`endif
   input  logic                   fifo_full,
   output logic                   fifo_wr_en,
   output logic [WD-1:0]          fifo_wdata,
   output logic [IDW-1:0]         grant_id,
   output logic                   busy
);

   localparam int unsigned BCW = $clog2(MAX_BURST + 1);

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;
   logic [IDW-1:0] last_grant_q, last_grant_d;
   logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
   logic [IDW-1:0] pick_id;
   logic           pick_any;

   rr_pick #(
      .NReq (NREQ)
   ) u_rr_pick (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (pick_id),
      .any_o        (pick_any)
   );

   assign busy     = (state_q == StBusy);
   assign grant_id = grant_id_q;

   // Combinational so fifo_full throttles the owner in the same cycle.
   always_comb begin
      req_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_wdata = '0;
      if (state_q == StBusy) begin
         req_ready[grant_id_q] = !fifo_full;
         fifo_wr_en            = req_valid[grant_id_q] && !fifo_full;
         fifo_wdata            = req_data[int'(grant_id_q) * int'(WD) +: WD];
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               grant_id_d = pick_id;
               beat_cnt_d = '0;
               state_d    = StBusy;
            end
         end
         StBusy: begin
            if (fifo_wr_en) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (req_last[grant_id_q] || (beat_cnt_q == BCW'(MAX_BURST - 1))) begin
                  last_grant_d = grant_id_q;
                  state_d      = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         grant_id_q   <= '0;
         last_grant_q <= IDW'(NREQ - 1);
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NREQ];

   // Clear wins over a same-cycle increment; counters stick at all-ones.
   always_ff @(posedge wclk) begin
      if (!rst_n || stat_clr) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            stat_q[i] <= '0;
         end
      end else if (fifo_wr_en && (stat_q[grant_id_q] != '1)) begin
         stat_q[grant_id_q] <= stat_q[grant_id_q] + 1'b1;
      end
   end

   always_comb begin
      stat_beats = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         stat_beats[i*STAT_W +: STAT_W] = stat_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level reference model.
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int WD        = 40;
   localparam int MAX_BURST = 8;
   localparam int IDW       = 2;

   logic              wclk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_last;
   logic [NREQ*WD-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic [WD-1:0]     fifo_wdata;
   logic [IDW-1:0]    grant_id;
   logic              busy;
   logic              stat_clr;
   logic [NREQ*16-1:0] stat_beats;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(
      .NREQ      (NREQ),
      .WD        (WD),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .wclk       (wclk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_data   (req_data),
      .req_ready  (req_ready),
`ifdef FIFO_WR_ARB_STATS_EN
      .stat_clr   (stat_clr),
      .stat_beats (stat_beats),
`endif
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_wdata (fifo_wdata),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the port, beats so far, who was served last.
   int m_owner = -1;
   int m_last  = NREQ - 1;
   int m_beats = 0;
   bit m_known = 1'b0;
   int m_stat [NREQ];

   int grants[$];
   int wr_cnt;
   bit prev_busy;
   int ord_all[5] = '{0, 1, 2, 3, 0};
   int ord_cap[5] = '{1, 2, 3, 0, 1};

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rand_data();
      logic [63:0] t;
      for (int i = 0; i < NREQ; i++) begin
         t = {$urandom, $urandom};
         req_data[i*WD +: WD] = t[WD-1:0];
      end
   endtask

   task automatic check_outputs();
      logic [NREQ-1:0] exp_ready;
      logic            exp_wr;
      logic [WD-1:0]   exp_data;
      if (!m_known) return;
      exp_ready = '0;
      exp_wr    = 1'b0;
      exp_data  = '0;
      if (m_owner >= 0) begin
         exp_ready[m_owner] = !fifo_full;
         exp_wr             = req_valid[m_owner] && !fifo_full;
         exp_data           = req_data[m_owner*WD +: WD];
         check_eq("grant_id", 64'(grant_id), 64'(m_owner));
      end
      check_eq("busy", 64'(busy), 64'(m_owner >= 0));
      check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
      check_eq("fifo_wr_en", 64'(fifo_wr_en), 64'(exp_wr));
      check_eq("fifo_wdata", 64'(fifo_wdata), 64'(exp_data));
`ifdef FIFO_WR_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) begin
         check_eq("stat_beats", 64'(stat_beats[i*16 +: 16]), 64'(m_stat[i]));
      end
`endif
   endtask

   task automatic model_update();
      bit wr;
      if (!rst_n) begin
         m_owner = -1;
         m_last  = NREQ - 1;
         m_beats = 0;
         m_known = 1'b1;
         for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
         return;
      end
      wr = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
`ifdef FIFO_WR_ARB_STATS_EN
      if (stat_clr) begin
         for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
      end else if (wr && m_stat[m_owner] < 65535) begin
         m_stat[m_owner]++;
      end
`endif
      if (m_owner < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            if (m_owner < 0 && req_valid[(m_last + k) % NREQ]) begin
               m_owner = (m_last + k) % NREQ;
               m_beats = 0;
            end
         end
      end else if (wr) begin
         m_beats++;
         if (req_last[m_owner] || m_beats == MAX_BURST) begin
            m_last  = m_owner;
            m_owner = -1;
         end
      end
   endtask

   task automatic tick();
      rand_data();
      #1;
      check_outputs();
      if (busy === 1'b1 && !prev_busy) grants.push_back(int'(grant_id));
      prev_busy = (busy === 1'b1);
      if (fifo_wr_en === 1'b1) wr_cnt++;
      @(posedge wclk);
      model_update();
      @(negedge wclk);
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      stat_clr  = 1'b0;
      rst_n     = 1'b1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      grants.delete();
      wr_cnt    = 0;
      prev_busy = 1'b0;
   endtask

   task automatic check_grants(input string tag, input int e[5]);
      for (int i = 0; i < 5; i++) begin
         check_eq(tag, 64'((i < grants.size()) ? grants[i] : 99), 64'(e[i]));
      end
   endtask

   initial begin
      int snap;
      for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
      clear_inputs();
      req_data = '0;
      rst_n    = 1'b0;
      @(negedge wclk);
      tick();
      do_reset();
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_gid", 64'(grant_id), 64'(0));

      // Single requester, 3-beat packet.
      for (int c = 0; c < 4; c++) begin
         req_valid = 4'b0100;
         req_last  = (c == 3) ? 4'b0100 : 4'b0000;
         tick();
      end
      check_eq("single_beats", 64'(wr_cnt), 64'(3));
      check_eq("single_gid", 64'((grants.size() > 0) ? grants[0] : 99), 64'(2));
      check_eq("single_busy_drop", 64'(busy), 64'(0));
      req_valid = '0;
      tick();

      // All valid, single-beat packets.
      do_reset();
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      for (int c = 0; c < 10; c++) tick();
      check_grants("rr_order", ord_all);
      check_eq("rr_writes", 64'(wr_cnt), 64'(5));

      // Requester 1 streams without last; burst cap forces release.
      do_reset();
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b1111;
      req_last  = 4'b1101;
      for (int c = 0; c < 17; c++) tick();
      check_grants("cap_order", ord_cap);
      check_eq("cap_writes", 64'(wr_cnt), 64'(13));

      // FIFO full for 5 cycles mid-burst.
      do_reset();
      req_valid = 4'b0001;
      snap = 0;
      for (int c = 0; c < 12; c++) begin
         fifo_full = (c >= 3 && c <= 7);
         req_last  = (c == 11) ? 4'b0001 : 4'b0000;
         if (c == 3) snap = wr_cnt;
         tick();
         if (c == 7) check_eq("full_no_writes", 64'(wr_cnt - snap), 64'(0));
      end
      check_eq("full_total_beats", 64'(wr_cnt), 64'(6));
      check_eq("full_release", 64'(busy), 64'(0));

      // Reset during beat 4.
      fifo_full = 1'b0;
      req_valid = 4'b1010;
      req_last  = 4'b0000;
      for (int c = 0; c < 4; c++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("midrst_busy", 64'(busy), 64'(0));
      check_eq("midrst_gid", 64'(grant_id), 64'(0));
      check_eq("midrst_wr", 64'(fifo_wr_en), 64'(0));
      tick();
      check_eq("midrst_first_gid", 64'(grant_id), 64'(1));
      check_eq("midrst_first_busy", 64'(busy), 64'(1));

      // Randomized traffic with occasional resets and stall.
      for (int c = 0; c < 3000; c++) begin
         req_valid = NREQ'($urandom);
         req_last  = NREQ'($urandom & $urandom);
         fifo_full = ($urandom_range(0, 3) == 0);
         rst_n     = ($urandom_range(0, 199) != 0);
`ifdef FIFO_WR_ARB_STATS_EN
         stat_clr  = ($urandom_range(0, 99) == 0);
`endif
         tick();
      end

`ifdef FIFO_WR_ARB_STATS_EN
      do_reset();
      req_valid = 4'b0001;
      req_last  = 4'b0000;
      for (int c = 0; c < 74000; c++) tick();
      check_eq("stat_sat", 64'(stat_beats[15:0]), 64'(16'hFFFF));
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check_eq("stat_clr", 64'(stat_beats[15:0]), 64'(0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
